// File: rtl/prog_seq_ctrl_pkg.sv
// Shared definitions for the program sequencer.
// Holds the FSM state encoding, default widths, the first executable address and
// the highest memory address.
package prog_seq_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W     = 4;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_FIRST_ADDR = 1;

  // Highest address of the 16-entry instruction memory.
  localparam int unsigned MEM_LAST = 15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/prog_seq_ctrl_if.sv
// Host byte stream plus instruction memory control bus.
//   in_valid/in_data/in_last/in_ready : host -> sequencer valid/ready byte stream
//   mem_state/mem_load/mem_pc/mem_instr : sequencer -> instruction memory
// master: host / memory side. slave: the sequencer.
interface prog_seq_ctrl_if
  import prog_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  logic              mem_state;
  logic              mem_load;
  logic [ADDR_W-1:0] mem_pc;
  logic [DATA_W-1:0] mem_instr;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_state, mem_load, mem_pc, mem_instr
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_state, mem_load, mem_pc, mem_instr
  );

endinterface

// File: rtl/prog_seq_ctrl.sv
// Program sequencer for the 16x8 instruction memory.
// Loads a host byte stream into addresses FIRST_ADDR..15, then steps the program
// counter through the program, paced by datapath step_done pulses, with jump and
// halt support.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start_load, run   phase requests (start_load wins)
//   step_done         datapath finished current instruction (qualifies jmp_en/halt_req)
//   jmp_en, jmp_addr  jump control
//   halt_req          stop after current instruction
//   bus               host stream + memory control (slave modport)
//   load_cnt          number of bytes loaded
//   busy, done        status: LOAD/RUN, HALT
module prog_seq_ctrl
  import prog_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIRST_ADDR = DEF_FIRST_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              run,
  input  logic              step_done,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt_req,
  prog_seq_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] load_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(MEM_LAST);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] load_cnt_q;
  logic              busy_q;
  logic              done_q;

  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] instr;

  // Combinational memory-side decode.
  assign in_ready = (state_q == S_LOAD);
  assign accept   = bus.in_valid & in_ready;
  assign instr    = accept ? bus.in_data : '0;

  assign bus.in_ready  = in_ready;
  assign bus.mem_load  = accept;
  assign bus.mem_instr = instr;
  assign bus.mem_state = (state_q == S_RUN);
  assign bus.mem_pc    = pc_q;

  assign load_cnt = load_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      load_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_READY, S_HALT: begin
          if (start_load) begin
            state_q    <= S_LOAD;
            pc_q       <= FirstAddr;
            load_cnt_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end else if (run && (state_q != S_IDLE || load_cnt_q != '0)) begin
            state_q <= S_RUN;
            pc_q    <= FirstAddr;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            load_cnt_q <= load_cnt_q + 1'b1;
            // Address 15 is the last slot; never wrap into address 0.
            if (bus.in_last || pc_q == LastAddr) begin
              state_q <= S_READY;
              pc_q    <= FirstAddr;
              busy_q  <= 1'b0;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (step_done) begin
            if (halt_req) begin
              state_q <= S_HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (jmp_en) begin
              pc_q <= jmp_addr;
            end else if (pc_q == load_cnt_q) begin
              state_q <= S_HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_seq_ctrl.md
Name: prog_seq_ctrl

Overview:
- Program sequencer for the 16x8 instruction memory; sole driver of its state, load, pc and instr_i inputs.
- Load phase: accepts a byte stream from the host over a valid/ready handshake and writes it to addresses 1..15 (address 0 is never written).
- Run phase: steps pc through the loaded program, paced by datapath completion pulses, with jump and halt support.

Parameters:
- ADDR_W, 4, pc / address width; memory depth 2**ADDR_W.
- DATA_W, 8, instruction width.
- FIRST_ADDR, 1, first writable/executable address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- start_load  in  1  request load phase; honoured in IDLE, READY, HALT.
- run  in  1  request execution; honoured in READY, HALT, and IDLE when load_cnt!=0.
- in_valid  in  1  host byte valid.
- in_data  in  DATA_W  host instruction byte.
- in_last  in  1  marks final byte; qualified by in_valid.
- in_ready  out  1  controller accepts a byte.
- step_done  in  1  datapath finished the current instruction; single-cycle pulse.
- jmp_en  in  1  qualified by step_done: next pc = jmp_addr.
- jmp_addr  in  ADDR_W  jump target.
- halt_req  in  1  qualified by step_done: stop after the current instruction.
- mem_state  out  1  memory state input; 1 = run/read, 0 = load.
- mem_load  out  1  memory write enable.
- mem_pc  out  ADDR_W  memory address / program counter.
- mem_instr  out  DATA_W  memory write data.
- load_cnt  out  ADDR_W  number of bytes loaded; last valid address = load_cnt.
- busy  out  1  high in LOAD and RUN.
- done  out  1  high in HALT.

Behaviour:
- FSM states: IDLE, LOAD, READY, RUN, HALT. On reset (rst low at a clk edge):
  - state -> IDLE; mem_pc=0, load_cnt=0.
  - mem_state=0, mem_load=0, in_ready=0, busy=0, done=0.
  - Takes effect mid-LOAD or mid-RUN identically; memory contents are not touched by the controller.
- IDLE:
  - start_load -> LOAD, mem_pc<=FIRST_ADDR, load_cnt<=0.
  - run with load_cnt!=0 -> RUN, mem_pc<=FIRST_ADDR.
  - start_load has priority over run in every state.
- LOAD:
  - in_ready=1 (combinational, from state only).
  - Accept = in_valid & in_ready. On accept, same cycle: mem_load=1, mem_instr=in_data, mem_pc=current address.
  - Next edge after accept: mem_pc+1, load_cnt+1.
  - Accept with in_last=1, or accept at mem_pc=15: -> READY, mem_pc<=FIRST_ADDR. The 15th byte is stored; no wrap to 0.
  - mem_load=0 whenever there is no accept; mem_instr=0 outside accept cycles.
- READY:
  - in_ready=0, mem_state=0.
  - run -> RUN with mem_pc=FIRST_ADDR.
  - start_load -> LOAD (load_cnt cleared, mem_pc=FIRST_ADDR).
- RUN:
  - mem_state=1; the memory presents instr at mem_pc combinationally, so fetch latency is 0 cycles.
  - mem_pc holds until step_done. On step_done, priority is:
    - halt_req -> HALT.
    - jmp_en -> mem_pc<=jmp_addr (jmp_addr=0 is legal; it reads the reset byte 0x00).
    - mem_pc==load_cnt -> HALT.
    - otherwise mem_pc+1.
  - A jump beyond load_cnt is legal; execution halts only via halt_req or by reaching load_cnt exactly. mem_pc wraps 15->0 via +1 only after a jump there.
  - start_load and run are ignored in RUN.
- HALT:
  - mem_state=0, done=1, mem_pc holds its last value.
  - run -> RUN, mem_pc<=FIRST_ADDR (re-execute).
  - start_load -> LOAD, load_cnt cleared.
- busy=1 in LOAD and RUN only.
- All outputs are registered except in_ready, mem_load, mem_instr and mem_state, which decode from state and inputs combinationally.

Decomposition:
- Shared package holds:
  - the FSM state encoding (3-bit localparams S_IDLE..S_HALT);
  - ADDR_W, DATA_W, FIRST_ADDR defaults;
  - the MEM_LAST=15 constant.
- Optional single sub-module pc_unit: holds mem_pc with load/increment/jump controls and the ==load_cnt compare. The FSM stays in the top module.

Test Plan:
- Reset, then start_load and bytes 0xA1,0xB2,0xC3 (in_last on 0xC3), then 3 write strobes -> mem_load high at pc 1,2,3 with matching mem_instr; load_cnt=3; state READY; mem_pc=1.
- run, then 3 step_done pulses -> mem_state=1, mem_pc sequence 1,2,3, then HALT with done=1, mem_pc=3.
- Load 16 bytes with no in_last -> bytes 1..15 accepted, in_ready drops after the 15th, load_cnt=15, no write to address 0.
- In RUN at pc=2, step_done with jmp_en=1, jmp_addr=5 -> mem_pc=5. Then step_done with halt_req=1 and jmp_en=1 -> HALT (halt wins).
- Stall in_valid for 4 cycles mid-load -> mem_load stays 0 and mem_pc is unchanged; the load resumes correctly.
- rst low during RUN at pc=4 -> next edge: IDLE, mem_pc=0, load_cnt=0, mem_state=0; run ignored until a new load.
